invmap: RTL and testbench
=========================

// Module: invmap
//
// PURPOSE
//  Inverse false-colour map: takes a 24-bit RGB pixel and returns the 8-bit
//  palette index whose entry is nearest to it. Nearest means smallest
//  Manhattan distance. The palette is a software-loaded 256x24 RAM.
//  Sits after the display colourmap to recover spectrogram magnitude from
//  rendered frames (screen-capture checking, colourmap round-trip tests).
//  Serial search, one palette entry per clock, with a valid/ready handshake
//  on both sides.
//
// PARAMETERS
//  LGN   8          log2 of palette depth
//  NCOL  (1<<LGN)   number of entries searched, always 0..NCOL-1
//
// PORTS
//  i_clk       in   1   system clock
//  i_reset     in   1   asynchronous, active-high reset
//  i_wr        in   1   palette write strobe
//  i_wr_addr   in   LGN palette write index
//  i_wr_rgb    in   24  palette write data {r,g,b}
//  i_valid     in   1   input pixel valid
//  o_ready     out  1   block can accept a pixel (state==IDLE)
//  i_rgb       in   24  input pixel {r[23:16],g[15:8],b[7:0]}
//  o_valid     out  1   result valid
//  i_ready     in   1   downstream accepts result
//  o_pixel     out  LGN best-match palette index
//  o_dist      out  10  distance of best match, |dr|+|dg|+|db|, 0..765
//
// BEHAVIOUR
//  - Reset: state=IDLE, o_valid=0, o_pixel=0, o_dist=0, so o_ready=1 after
//    reset. Palette RAM is not reset; its contents survive reset.
//  - Palette writes take effect only in IDLE. i_wr in SEARCH or DONE is
//    dropped.
//  - FSM:
//      IDLE -> SEARCH on i_valid&&o_ready. i_rgb is latched at that edge;
//        call it T.
//      SEARCH: RAM read of entry k is registered at edge T+1+k.
//        The compare for entry k updates best at edge T+2+k.
//        Update only if dist < best_dist (strict). Ties therefore resolve
//        to the lowest index. best_dist starts at 10'h3ff.
//      SEARCH -> DONE at edge T+NCOL+2. o_valid goes high, so latency is
//        NCOL+2 cycles.
//      DONE: o_pixel and o_dist are held stable while i_ready=0.
//        On o_valid&&i_ready -> IDLE, o_valid=0.
//  - o_ready=0 in DONE, so a pixel and a result never handshake on the same
//    edge. The next accept is at the earliest one cycle after the result
//    handshake.
//  - Arithmetic: each |d| is 8 bits unsigned. Sum is 10 bits, no saturation
//    needed.
//  - Address counter is LGN+1 bits so that NCOL is reachable. It never wraps
//    into a second pass.
//  - i_reset mid-SEARCH or mid-DONE aborts immediately. Result is discarded,
//    o_valid=0, back to IDLE.
//
// CONFIGURATION
//  INVMAP_EARLY_EXIT_EN
//    defined: a compare with dist==0 for entry k ends the search.
//      DONE and o_valid at edge T+k+3, o_pixel=k, o_dist=0.
//      Later entries are never examined.
//    undefined: always a full NCOL-entry search with NCOL+2 latency.
//      The reported result is identical; only latency differs.
//
// TESTING
//  1. Grey ramp: entry k={k,k,k}, input 24'h404040 -> o_pixel=8'h40,
//     o_dist=0. o_valid at T+258 (macro off) or T+67 (macro on).
//  2. Tie: entry 5=24'h100000, entry 9=24'h000010, all others 24'hffffff.
//     Input 24'h080008 -> o_pixel=5, o_dist=16.
//  3. Backpressure: hold i_ready=0 for 10 cycles after o_valid.
//     -> o_pixel and o_dist stable, o_ready=0 throughout. After the
//     handshake, o_ready=1 on the next cycle and o_valid=0.
//  4. Assert i_reset at T+100 for one cycle.
//     -> o_valid=0, o_ready=1. Palette is retained. A re-issued pixel
//     returns the same result as test 1.
//  5. During SEARCH, write entry 3=exact copy of input. Old entry 3 was far.
//     -> result ignores the write. A re-run after IDLE returns o_pixel=3,
//     o_dist=0.
//  6. Macro on: exact match at entry 2 only -> o_valid at T+5, o_pixel=2.
//     Macro off, same stimulus -> o_valid at T+258, o_pixel=2.

Source files
------------

// File: rtl/invmap.sv
// Inverse false-colour map: serial nearest-palette-entry search.
//
// Takes a 24-bit {r,g,b} pixel and returns the index of the palette entry
// with the smallest Manhattan distance |dr|+|dg|+|db|. The palette is a
// software-loaded NCOL x 24 RAM that is writable only while idle. One
// entry is examined per clock. Ties resolve to the lowest index.
//
// Ports:
//   i_clk, i_reset        clock, asynchronous active-high reset
//   i_wr/i_wr_addr/i_wr_rgb  palette write port (honoured only in idle)
//   i_valid/o_ready/i_rgb    pixel input handshake
//   o_valid/i_ready          result output handshake
//   o_pixel/o_dist           best-match index and its distance (0..765)
//
// Build option:
//   INVMAP_EARLY_EXIT_EN  when defined, an exact match (distance 0) ends
//                         the search immediately; results are unchanged,
//                         only latency differs.
module invmap #(
  parameter int unsigned LGN  = 8,
  parameter int unsigned NCOL = 1 << LGN
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_wr,
  input  logic [LGN-1:0] i_wr_addr,
  input  logic [23:0]    i_wr_rgb,
  input  logic           i_valid,
  output logic           o_ready,
  input  logic [23:0]    i_rgb,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [LGN-1:0] o_pixel,
  output logic [9:0]     o_dist
);

  typedef enum logic [1:0] {StIdle, StSearch, StDone} state_t;

  localparam logic [LGN:0] AddrEnd = (LGN+1)'(NCOL);

  state_t         state_q, state_d;
  logic [LGN:0]   addr_q;       // next entry to read; stops at NCOL
  logic [23:0]    pix_q;        // latched target pixel
  logic [23:0]    rd_q;         // registered palette read data
  logic           rdv_q;        // rd_q holds a live entry to compare
  logic [9:0]     best_dist_q;
  logic [LGN-1:0] best_idx_q;
  logic [LGN-1:0] pixel_q;
  logic [9:0]     dist_q;
  logic [23:0]    mem [NCOL];

  logic           search_end;
  logic [9:0]     cand_dist;
  logic [LGN-1:0] cand_idx;
  logic           upd;

  function automatic logic [7:0] absdiff(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  assign cand_dist = {2'b00, absdiff(rd_q[23:16], pix_q[23:16])}
                   + {2'b00, absdiff(rd_q[15:8],  pix_q[15:8])}
                   + {2'b00, absdiff(rd_q[7:0],   pix_q[7:0])};

  // The entry in rd_q was read from addr_q-1 on the previous edge.
  assign cand_idx = addr_q[LGN-1:0] - LGN'(1);

  // Search ends one edge after the final compare has been absorbed.
`ifdef INVMAP_EARLY_EXIT_EN
  assign search_end = ((addr_q == AddrEnd) && !rdv_q) || (best_dist_q == 10'd0);
`else
  assign search_end = (addr_q == AddrEnd) && !rdv_q;
`endif

  assign upd = (state_q == StSearch) && rdv_q && !search_end && (cand_dist < best_dist_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (i_valid)    state_d = StSearch;
      StSearch: if (search_end) state_d = StDone;
      StDone:   if (i_ready)    state_d = StIdle;
      default:                  state_d = StIdle;
    endcase
  end

  assign o_ready = (state_q == StIdle);
  assign o_valid = (state_q == StDone);
  assign o_pixel = pixel_q;
  assign o_dist  = dist_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      pix_q       <= '0;
      rdv_q       <= 1'b0;
      best_dist_q <= 10'h3ff;
      best_idx_q  <= '0;
      pixel_q     <= '0;
      dist_q      <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (i_valid) begin
            pix_q       <= i_rgb;
            addr_q      <= '0;
            rdv_q       <= 1'b0;
            best_dist_q <= 10'h3ff;
            best_idx_q  <= '0;
          end
        end
        StSearch: begin
          rdv_q <= (addr_q != AddrEnd) && !search_end;
          if (addr_q != AddrEnd) addr_q <= addr_q + 1'b1;
          if (upd) begin
            best_dist_q <= cand_dist;
            best_idx_q  <= cand_idx;
          end
          if (search_end) begin
            pixel_q <= best_idx_q;
            dist_q  <= best_dist_q;
          end
        end
        default: ;
      endcase
    end
  end

  // Palette RAM: not reset, so contents survive i_reset.
  always_ff @(posedge i_clk) begin
    if (i_wr && (state_q == StIdle)) mem[i_wr_addr] <= i_wr_rgb;
    rd_q <= mem[addr_q[LGN-1:0]];
  end

endmodule

// File: tb/tb_invmap.sv
module tb_invmap;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr = 1'b0;
  logic [7:0]  wa = '0;
  logic [23:0] wd = '0;
  logic        valid = 1'b0;
  logic        ready_o;
  logic [23:0] rgb = '0;
  logic        valid_o;
  logic        rdy = 1'b0;
  logic [7:0]  pixel_o;
  logic [9:0]  dist_o;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  int t0     = 0;
  logic [23:0] pal [256];

  invmap dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_wr      (wr),
    .i_wr_addr (wa),
    .i_wr_rgb  (wd),
    .i_valid   (valid),
    .o_ready   (ready_o),
    .i_rgb     (rgb),
    .o_valid   (valid_o),
    .i_ready   (rdy),
    .o_pixel   (pixel_o),
    .o_dist    (dist_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", name, obs, exp);
    end
  endtask

  function automatic int ad(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Reference: exhaustive nearest-entry search over the palette array.
  task automatic model(input logic [23:0] px, output int idx, output int d, output int lat);
    int dk;
    int first_zero;
    idx = 0; d = 1023; first_zero = -1;
    for (int k = 0; k < 256; k++) begin
      dk = ad(int'(pal[k][23:16]), int'(px[23:16])) + ad(int'(pal[k][15:8]), int'(px[15:8]))
         + ad(int'(pal[k][7:0]), int'(px[7:0]));
      if (dk < d) begin d = dk; idx = k; end
      if (dk == 0 && first_zero < 0) first_zero = k;
    end
    lat = 258;
`ifdef INVMAP_EARLY_EXIT_EN
    if (first_zero >= 0) lat = first_zero + 3;
`endif
  endtask

  task automatic pwrite(input int a, input logic [23:0] d);
    wr = 1'b1; wa = 8'(a); wd = d;
    @(posedge clk); #1;
    wr = 1'b0;
    pal[a] = d;
  endtask

  task automatic start(input logic [23:0] px);
    check("ready_before_accept", 32'(ready_o), 1);
    valid = 1'b1; rgb = px;
    @(posedge clk); #1;
    valid = 1'b0;
    t0 = cyc;
  endtask

  task automatic result(input string name, input int ep, input int ed, input int lat, input int hold);
    logic [7:0] p0;
    logic [9:0] d0;
    while (!valid_o && (cyc - t0) < 400) begin
      @(posedge clk); #1;
    end
    check({name, "_valid"}, 32'(valid_o), 1);
    check({name, "_latency"}, 32'(cyc - t0), 32'(lat));
    check({name, "_pixel"}, 32'(pixel_o), 32'(ep));
    check({name, "_dist"}, 32'(dist_o), 32'(ed));
    check({name, "_ready_in_done"}, 32'(ready_o), 0);
    p0 = pixel_o; d0 = dist_o;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({name, "_hold_pixel"}, 32'(pixel_o), 32'(p0));
      check({name, "_hold_dist"}, 32'(dist_o), 32'(d0));
      check({name, "_hold_valid"}, 32'(valid_o), 1);
      check({name, "_hold_ready"}, 32'(ready_o), 0);
    end
    rdy = 1'b1;
    @(posedge clk); #1;
    rdy = 1'b0;
    check({name, "_valid_after_hs"}, 32'(valid_o), 0);
    check({name, "_ready_after_hs"}, 32'(ready_o), 1);
  endtask

  initial begin
    int mi, md, ml;
    logic [23:0] px;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_ready", 32'(ready_o), 1);
    check("reset_valid", 32'(valid_o), 0);
    check("reset_pixel", 32'(pixel_o), 0);
    check("reset_dist", 32'(dist_o), 0);

    // Grey ramp
    for (int k = 0; k < 256; k++) pwrite(k, {8'(k), 8'(k), 8'(k)});
    model(24'h404040, mi, md, ml);
    start(24'h404040);
    result("grey", 8'h40, 0, ml, 0);

    // Backpressure on the same pixel
    start(24'h404040);
    result("backpressure", 8'h40, 0, ml, 10);

    // Reset mid-search, palette retained
    start(24'h404040);
    repeat (99) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("midreset_valid", 32'(valid_o), 0);
    check("midreset_ready", 32'(ready_o), 1);
    start(24'h404040);
    result("after_reset", 8'h40, 0, ml, 0);

    // Write during search is dropped
    model(24'h00ff00, mi, md, ml);
    start(24'h00ff00);
    wr = 1'b1; wa = 8'd3; wd = 24'h00ff00;
    @(posedge clk); #1 wr = 1'b0;
    result("wr_in_search", mi, md, ml, 0);
    check("wr_in_search_model_pixel", 32'(mi), 0);
    pwrite(3, 24'h00ff00);
    model(24'h00ff00, mi, md, ml);
    start(24'h00ff00);
    result("wr_in_idle", 3, 0, ml, 0);

    // Tie resolves to lowest index
    for (int k = 0; k < 256; k++) pwrite(k, 24'hffffff);
    pwrite(5, 24'h100000);
    pwrite(9, 24'h000010);
    model(24'h080008, mi, md, ml);
    start(24'h080008);
    result("tie", 5, 16, ml, 0);

    // Exact match at entry 2 only
    pwrite(5, 24'hffffff);
    pwrite(9, 24'hffffff);
    pwrite(2, 24'h123456);
    model(24'h123456, mi, md, ml);
`ifdef INVMAP_EARLY_EXIT_EN
    check("exact2_model_lat", 32'(ml), 5);
`else
    check("exact2_model_lat", 32'(ml), 258);
`endif
    start(24'h123456);
    result("exact2", 2, 0, ml, 0);

    // Random palette and pixels
    for (int k = 0; k < 256; k++) pwrite(k, 24'($urandom));
    for (int n = 0; n < 8; n++) begin
      if (n % 3 == 0) px = pal[$urandom_range(255, 0)];
      else px = 24'($urandom);
      model(px, mi, md, ml);
      start(px);
      result("random", mi, md, ml, int'($urandom_range(2, 0)));
    end

    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
